// File: rtl/jt51_slot_sched.sv
// Slot counter and write injector for one JT51 32-slot recirculating delay line.
// Queued register writes are spliced into the ring as their target slot passes.
module jt51_slot_sched #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 32,
  parameter int DEPTH  = 4,
  localparam int SW    = $clog2(STAGES),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SW-1:0]    req_slot,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] drop,
  output logic [WIDTH-1:0] din,
  output logic [SW-1:0]    slot,
  output logic             zero,
  output logic             inj,
  output logic [LW-1:0]    level
);

  localparam int AW = LW - 1;

  logic [SW-1:0]    r_slot;
  logic             r_zero;
  logic [LW-1:0]    r_level;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [SW-1:0]    r_mem_slot [DEPTH];
  logic [WIDTH-1:0] r_mem_data [DEPTH];

  logic             w_inj;
  logic             w_push;
  logic [SW-1:0]    w_head_slot;
  logic [WIDTH-1:0] w_head_data;

  assign w_head_slot = r_mem_slot[r_rp];
  assign w_head_data = r_mem_data[r_rp];

  // Only the head may inject; later entries wait even if their slot comes first.
  assign w_inj     = cen & (r_level != '0) & (w_head_slot == r_slot) & rst_n;
  assign req_ready = (r_level < LW'(DEPTH)) | w_inj;
  assign w_push    = req_valid & req_ready & rst_n;

  assign din   = w_inj ? w_head_data : drop;
  assign inj   = w_inj;
  assign slot  = r_slot;
  assign zero  = r_zero;
  assign level = r_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_zero  <= 1'b1;
      r_level <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
    end else begin
      if (cen) begin
        r_slot <= r_slot + 1'b1;
        r_zero <= (r_slot == SW'(STAGES - 1));
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_inj)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_inj})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Payload storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_slot[r_wp] <= req_slot;
      r_mem_data[r_wp] <= req_data;
    end
  end

endmodule

// File: tb/tb_jt51_slot_sched.sv
// Directed bench for jt51_slot_sched with a 32-deep delay-line model closing the ring.
module tb_jt51_slot_sched;
  localparam int W  = 5;
  localparam int ST = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cen = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [4:0]   req_slot = '0;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] drop = '0;
  logic [W-1:0] din;
  logic [4:0]   slot;
  logic         zero;
  logic         inj;
  logic [2:0]   level;

  jt51_slot_sched #(.WIDTH(W), .STAGES(ST), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_slot(req_slot), .req_data(req_data),
    .drop(drop), .din(din), .slot(slot), .zero(zero),
    .inj(inj), .level(level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] line [ST];
  int           ms = 0;
  int           pslot;
  int           tcount = 0;
  logic [W-1:0] dsamp;
  logic         isamp;
  logic         acc;
  logic         rsamp;

  int           ir_n;
  int           ir_slot [2];
  int           ir_dat  [2];
  int           ir_t    [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive cen/drop, sample combinational outputs, advance the ring model.
  task automatic tick(input logic c);
    cen  = c;
    drop = line[ms];
    #2;
    dsamp = din;
    isamp = inj;
    rsamp = req_ready;
    acc   = req_valid & req_ready & rst_n;
    pslot = ms;
    @(posedge clk);
    #1;
    tcount++;
    if (!rst_n) ms = 0;
    else if (c) begin
      line[ms] = dsamp;
      ms = (ms + 1) % ST;
    end
  endtask

  task automatic push(input int s, input int d, input logic c);
    req_valid = 1'b1;
    req_slot  = 5'(s);
    req_data  = W'(d);
    tick(c);
    check("push_acc", acc, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic pair(input int st, input int s1, input int d1, input int s2, input int d2);
    while (ms != st) tick(1'b1);
    push(s1, d1, 1'b1);
    push(s2, d2, 1'b1);
    ir_n = 0;
    for (int i = 0; i < 70; i++) begin
      tick(1'b1);
      if (isamp) begin
        if (ir_n < 2) begin
          ir_slot[ir_n] = pslot;
          ir_dat[ir_n]  = int'(dsamp);
          ir_t[ir_n]    = tcount;
        end
        ir_n++;
      end
    end
  endtask

  initial begin
    int bad;
    int cnt;
    int last;
    for (int i = 0; i < ST; i++) line[i] = '0;

    // Reset with random drop, alternating cen and a request that must be ignored.
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_slot = 5'd9;
    req_data = 5'h15;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cen  = i[0];
      drop = W'($urandom_range(0, 31));
      #2;
      check("rst_inj", inj, 1'b0);
      check("rst_din", din, drop);
      check("rst_ready", req_ready, 1'b1);
      @(posedge clk);
      #1;
      check("rst_slot", slot, 5'd0);
      check("rst_zero", zero, 1'b1);
      check("rst_level", level, 3'd0);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    ms = 0;
    for (int i = 0; i < 31; i++) tick(1'b1);
    check("slot_31", slot, 5'd31);
    check("zero_31", zero, 1'b0);
    tick(1'b1);
    check("slot_wrap", slot, 5'd0);
    check("zero_wrap", zero, 1'b1);

    // Single write {5, 0x1A} pushed at slot 2.
    while (ms != 2) tick(1'b1);
    push(5, 'h1A, 1'b1);
    check("sw_level1", level, 3'd1);
    bad = 0;
    while (ms != 5) begin
      tick(1'b1);
      if (isamp) bad++;
    end
    check("sw_early_inj", bad, 0);
    tick(1'b1);
    check("sw_inj", isamp, 1'b1);
    check("sw_din", dsamp, 5'h1A);
    check("sw_level0", level, 3'd0);
    bad = 0;
    for (int i = 0; i < 31; i++) begin
      tick(1'b1);
      if (isamp || dsamp !== drop) bad++;
    end
    check("sw_recirc", bad, 0);
    check("sw_slot_align", slot, 5'(ms));
    tick(1'b1);
    check("sw_ring_slot5", dsamp, 5'h1A);
    check("sw_ring_noinj", isamp, 1'b0);

    // Fill the FIFO with cen low, then a push and a pop share the slot-7 cycle.
    for (int k = 1; k <= 4; k++) push(7, k, 1'b0);
    check("full_level", level, 3'd4);
    check("full_ready", req_ready, 1'b0);
    req_valid = 1'b1;
    req_slot = 5'd7;
    req_data = 5'd5;
    tick(1'b0);
    check("full_held", acc, 1'b0);
    bad = 0;
    while (ms != 7) begin
      tick(1'b1);
      if (acc || isamp) bad++;
    end
    check("full_wait", bad, 0);
    tick(1'b1);
    check("full_inj", isamp, 1'b1);
    check("full_din", dsamp, 5'd1);
    check("full_ready_inj", rsamp, 1'b1);
    check("full_acc5", acc, 1'b1);
    check("full_level_kept", level, 3'd4);
    req_valid = 1'b0;
    cnt = 0;
    last = 0;
    for (int i = 0; i < 4 * ST; i++) begin
      tick(1'b1);
      if (isamp) begin
        cnt++;
        last = int'(dsamp);
        if (pslot != 7) bad++;
      end
    end
    check("drain_count", cnt, 4);
    check("drain_last", last, 5);
    check("drain_slot", bad, 0);
    check("drain_level", level, 3'd0);

    // Head-of-line ordering.
    pair(4, 10, 'h03, 3, 'h11);
    check("hol_n", ir_n, 2);
    check("hol_s0", ir_slot[0], 10);
    check("hol_d0", ir_dat[0], 'h03);
    check("hol_s1", ir_slot[1], 3);
    check("hol_d1", ir_dat[1], 'h11);
    pair(12, 10, 'h0C, 14, 'h0D);
    check("hol2_n", ir_n, 2);
    check("hol2_s0", ir_slot[0], 10);
    check("hol2_s1", ir_slot[1], 14);
    check("hol2_d1", ir_dat[1], 'h0D);

    // Duplicate slot: injections one rotation apart, later value survives.
    pair(4, 20, 'h05, 20, 'h06);
    check("dup_n", ir_n, 2);
    check("dup_gap", ir_t[1] - ir_t[0], ST);
    check("dup_d0", ir_dat[0], 'h05);
    check("dup_d1", ir_dat[1], 'h06);
    while (ms != 20) tick(1'b1);
    tick(1'b1);
    check("dup_ring", dsamp, 5'h06);
    check("dup_ring_noinj", isamp, 1'b0);

    // Reset with three entries queued, head two slots away.
    while (ms != 10) tick(1'b1);
    push(15, 1, 1'b1);
    push(16, 2, 1'b1);
    push(17, 3, 1'b1);
    check("mid_level3", level, 3'd3);
    check("mid_slot13", slot, 5'd13);
    rst_n = 1'b0;
    tick(1'b1);
    check("mid_rst_inj", isamp, 1'b0);
    check("mid_level0", level, 3'd0);
    check("mid_slot0", slot, 5'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2 * ST; i++) begin
      tick(1'b1);
      if (isamp) bad++;
    end
    check("mid_no_inj", bad, 0);
    check("mid_level_end", level, 3'd0);
    check("mid_slot_align", slot, 5'(ms));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
